spi_slave_port: RTL and testbench

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

---
 rtl/spi_slave_port.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_slave_port.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_port.sv
// -----------------------------------------------------------------------------
// spi_slave_port
//
// SPI mode-0 (CPOL=0, CPHA=0) slave port, fully synchronous to the system
// clock. The pin-level sclk, cs_n and mosi are brought into the clk domain
// through 2-flop synchronizers. sclk and cs_n get a third flop so their edges
// can be detected.
//
// Ports
//   clk         system clock, at least 4x the sclk frequency
//   rst_n       asynchronous active-low reset
//   sclk        SPI serial clock from the master (asynchronous)
//   cs_n        active-low chip select (asynchronous)
//   mosi        serial data from the master, MSB first
//   miso        serial data to the master, MSB first
//   miso_oe     enable for the external miso tri-state buffer
//   rx_data     last completely received word
//   rx_valid    one-clk pulse when rx_data has been updated
//   tx_data     next word to transmit
//   tx_valid    tx_data is available
//   tx_ready    tx_data is taken this cycle if tx_valid=1
//
// Optional feature (macro SPI_SLAVE_ERR_EN)
//   frame_err   one-clk pulse when a word is abandoned by cs_n rising mid-word
//   tx_underrun one-clk pulse when TX_IDLE is loaded because tx_valid was 0
// -----------------------------------------------------------------------------
module spi_slave_port #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic                  frame_err,
    output logic                  tx_underrun
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Synchronizer chains: bit 0 is the metastability flop, bit 1 the
    // synchronized value, bit 2 (sclk/cs_n only) the delayed copy for edges.
    logic [2:0]            sclk_sync_r;
    logic [2:0]            cs_sync_r;
    logic [1:0]            mosi_sync_r;
    logic [1:0]            sync_ok_r;
    logic                  armed_r;

    state_t                state_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] rx_shift_r;
    logic [DATA_WIDTH-1:0] tx_shift_r;
    logic [DATA_WIDTH-1:0] rx_data_r;
    logic                  rx_valid_r;
    logic                  tx_ready_r;
    logic                  miso_oe_r;
    logic                  word_done_r;
`ifdef SPI_SLAVE_ERR_EN
    logic                  frame_err_r;
    logic                  tx_underrun_r;
`endif

    logic                  sclk_rise_s;
    logic                  sclk_fall_s;
    logic                  cs_fall_s;
    logic                  cs_high_s;
    logic                  mosi_s;
    logic                  last_rise_s;
    logic [DATA_WIDTH-1:0] rx_shift_in_s;
    logic [DATA_WIDTH-1:0] tx_next_s;

    assign sclk_rise_s   = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign sclk_fall_s   = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign cs_fall_s     = ~cs_sync_r[1] & cs_sync_r[2];
    assign cs_high_s     = cs_sync_r[1];
    assign mosi_s        = mosi_sync_r[1];
    assign last_rise_s   = sclk_rise_s & (bit_cnt_r == LAST_BIT);
    assign rx_shift_in_s = {rx_shift_r[DATA_WIDTH-2:0], mosi_s};
    assign tx_next_s     = tx_valid ? tx_data : TX_IDLE;

    assign miso     = tx_shift_r[DATA_WIDTH-1];
    assign miso_oe  = miso_oe_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign tx_ready = tx_ready_r;
`ifdef SPI_SLAVE_ERR_EN
    assign frame_err   = frame_err_r;
    assign tx_underrun = tx_underrun_r;
`endif

    // Input synchronizers plus a post-reset arming flag. The chains reset to
    // the idle levels, so a cs_n still held low by the master after reset
    // would look like a fresh falling edge; armed_r only sets once a real
    // (post-reset) high level of cs_n has reached the synchronized tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b111;
            mosi_sync_r <= 2'b00;
            sync_ok_r   <= 2'b00;
            armed_r     <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], sclk};
            cs_sync_r   <= {cs_sync_r[1:0], cs_n};
            mosi_sync_r <= {mosi_sync_r[0], mosi};
            sync_ok_r   <= {sync_ok_r[0], 1'b1};
            if (sync_ok_r[1] && cs_sync_r[1]) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // Transfer FSM with its shift registers, bit counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= CNT_ZERO;
            rx_shift_r  <= WORD_ZERO;
            tx_shift_r  <= WORD_ZERO;
            rx_data_r   <= WORD_ZERO;
            rx_valid_r  <= 1'b0;
            tx_ready_r  <= 1'b0;
            miso_oe_r   <= 1'b0;
            word_done_r <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            frame_err_r   <= 1'b0;
            tx_underrun_r <= 1'b0;
`endif
        end else begin
            rx_valid_r  <= 1'b0;
            tx_ready_r  <= 1'b0;
            word_done_r <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            frame_err_r   <= 1'b0;
            tx_underrun_r <= 1'b0;
`endif
            // Second stage of word completion: publish the word one clk after
            // the last bit was shifted in, independent of the FSM state so a
            // word finished together with deselect is still delivered.
            if (word_done_r) begin
                rx_data_r  <= rx_shift_r;
                rx_valid_r <= 1'b1;
            end else begin
                rx_data_r  <= rx_data_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s && armed_r) begin
                        state_r    <= ST_LOAD;
                        tx_ready_r <= 1'b1;
                        miso_oe_r  <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end

                ST_LOAD: begin
                    state_r    <= ST_SHIFT;
                    bit_cnt_r  <= CNT_ZERO;
                    tx_shift_r <= tx_next_s;
`ifdef SPI_SLAVE_ERR_EN
                    tx_underrun_r <= ~tx_valid;
`endif
                end

                ST_SHIFT: begin
                    if (cs_high_s) begin
                        // Deselected. A final-bit rising edge seen in the same
                        // cycle still completes the word; anything else is a
                        // partial word and is dropped.
                        state_r    <= ST_IDLE;
                        miso_oe_r  <= 1'b0;
                        tx_shift_r <= WORD_ZERO;
                        bit_cnt_r  <= CNT_ZERO;
                        if (last_rise_s) begin
                            rx_shift_r  <= rx_shift_in_s;
                            word_done_r <= 1'b1;
                        end else begin
                            rx_shift_r  <= WORD_ZERO;
`ifdef SPI_SLAVE_ERR_EN
                            frame_err_r <= (bit_cnt_r != CNT_ZERO) | sclk_rise_s;
`endif
                        end
                    end else if (sclk_rise_s) begin
                        rx_shift_r <= rx_shift_in_s;
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_r   <= CNT_ZERO;
                            word_done_r <= 1'b1;
                            tx_ready_r  <= 1'b1;
                        end else begin
                            bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
                        end
                    end else if (tx_ready_r) begin
                        // Reload for a back-to-back word; lands before the
                        // trailing falling edge of the previous word's last bit.
                        tx_shift_r <= tx_next_s;
`ifdef SPI_SLAVE_ERR_EN
                        tx_underrun_r <= ~tx_valid;
`endif
                    end else if (sclk_fall_s && (bit_cnt_r != CNT_ZERO)) begin
                        // The falling edge right after a word's last bit (counter
                        // already wrapped to 0) must not shift, or the freshly
                        // loaded MSB would be lost.
                        tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    bit_cnt_r  <= CNT_ZERO;
                    rx_shift_r <= WORD_ZERO;
                    tx_shift_r <= WORD_ZERO;
                    miso_oe_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_port.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_port
//
// Directed testbench for spi_slave_port. A behavioural SPI mode-0 master
// drives sclk/cs_n/mosi and samples miso on sclk rising edges. A tx producer
// answers tx_ready handshakes, and a negedge monitor logs rx_valid words and
// counts pulses. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_port;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
`ifdef SPI_SLAVE_ERR_EN
    logic       frame_err;
    logic       tx_underrun;
`endif

    int         total = 0;
    int         bad   = 0;

    int         rx_cnt = 0;
    int         oe_cnt = 0;
    int         hs_cnt = 0;
    int         fe_cnt = 0;
    int         ur_cnt = 0;
    logic [7:0] rx_log [0:3];

    logic       tx_hold = 1'b0;
    logic [7:0] tx_q [0:3];
    int         tx_num = 0;
    int         tx_idx = 0;

    logic [7:0] mi;

    spi_slave_port #(
        .DATA_WIDTH (8),
        .TX_IDLE    (8'hFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
`ifdef SPI_SLAVE_ERR_EN
        ,
        .frame_err   (frame_err),
        .tx_underrun (tx_underrun)
`endif
    );

    // 100 MHz system clock; sclk runs at 1/8 of it
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output monitor, sampled on the inactive clock edge
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_cnt < 4) rx_log[rx_cnt] = rx_data;
            rx_cnt++;
        end
        if (miso_oe) oe_cnt++;
`ifdef SPI_SLAVE_ERR_EN
        if (frame_err) fe_cnt++;
        if (tx_underrun) ur_cnt++;
`endif
    end

    // tx producer: on a handshake, advance to the next queued word after the
    // consuming clock edge, or drop tx_valid when the queue is exhausted
    initial begin
        forever begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                if (!tx_hold) begin
                    @(posedge clk);
                    #1;
                    if (tx_idx < tx_num) begin
                        tx_data = tx_q[tx_idx];
                        tx_idx++;
                    end else begin
                        tx_valid = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        rx_cnt = 0;
        oe_cnt = 0;
        hs_cnt = 0;
        fe_cnt = 0;
        ur_cnt = 0;
    endtask

    // Mode-0 master: shift out the top nbits of mo, MSB first; sample miso on
    // each rising edge. With cs_up_last, cs_n rises together with the last
    // rising edge.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits,
                            input logic cs_up_last, output logic [7:0] mo_in);
        mo_in = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = mo[i];
            #40;
            sclk = 1'b1;
            mo_in[i] = miso;
            if (i == 0 && cs_up_last) cs_n = 1'b1;
            #40;
            sclk = 1'b0;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_log[i] = 8'h00;
            tx_q[i]   = 8'h00;
        end

        // Reset state
        #20;
        chk("rst_rx_data",  16'(rx_data),  16'h0000);
        chk("rst_rx_valid", 16'(rx_valid), 16'h0000);
        chk("rst_tx_ready", 16'(tx_ready), 16'h0000);
        chk("rst_miso",     16'(miso),     16'h0000);
        chk("rst_miso_oe",  16'(miso_oe),  16'h0000);
        rst_n = 1'b1;
        #100;

        // Single word 0xA5 in, 0x3C out; cs_n rises with the final bit
        clear_counts();
        tx_hold  = 1'b1;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        cs_n = 1'b0;
        #100;
        spi_xfer(8'hA5, 8, 1'b1, mi);
        #200;
        chk("a5_rx_count", 16'(rx_cnt),    16'd1);
        chk("a5_rx_log",   16'(rx_log[0]), 16'h00A5);
        chk("a5_rx_data",  16'(rx_data),   16'h00A5);
        chk("a5_miso",     16'(mi),        16'h003C);
        chk("a5_oe_seen",  16'(oe_cnt > 0), 16'd1);
        chk("a5_oe_after", 16'(miso_oe),   16'h0000);
        chk("a5_miso_idle",16'(miso),      16'h0000);
        tx_hold  = 1'b0;
        tx_valid = 1'b0;

        // Back-to-back words 0x12, 0x34 with tx 0x56, 0x78
        clear_counts();
        tx_q[0]  = 8'h78;
        tx_num   = 1;
        tx_idx   = 0;
        tx_data  = 8'h56;
        tx_valid = 1'b1;
        cs_n = 1'b0;
        #100;
        spi_xfer(8'h12, 8, 1'b0, mi);
        chk("b2b_miso0", 16'(mi), 16'h0056);
        spi_xfer(8'h34, 8, 1'b0, mi);
        chk("b2b_miso1", 16'(mi), 16'h0078);
        #100;
        cs_n = 1'b1;
        #200;
        chk("b2b_rx_count", 16'(rx_cnt),    16'd2);
        chk("b2b_rx0",      16'(rx_log[0]), 16'h0012);
        chk("b2b_rx1",      16'(rx_log[1]), 16'h0034);
        chk("b2b_tx_hs",    16'(hs_cnt),    16'd2);
        tx_valid = 1'b0;

        // cs_n raised after 5 bits: partial word dropped, then 0xC3
        clear_counts();
        cs_n = 1'b0;
        #100;
        spi_xfer(8'hB0, 5, 1'b0, mi);
        #40;
        cs_n = 1'b1;
        #200;
        chk("abort_rx_count", 16'(rx_cnt),  16'd0);
        chk("abort_rx_data",  16'(rx_data), 16'h0034);
`ifdef SPI_SLAVE_ERR_EN
        chk("abort_frame_err", 16'(fe_cnt), 16'd1);
`endif
        clear_counts();
        cs_n = 1'b0;
        #100;
        spi_xfer(8'hC3, 8, 1'b0, mi);
        #100;
        cs_n = 1'b1;
        #200;
        chk("c3_rx_count", 16'(rx_cnt),  16'd1);
        chk("c3_rx_data",  16'(rx_data), 16'h00C3);

        // Reset after 3 bits, then fresh transfer 0x81
        clear_counts();
        cs_n = 1'b0;
        #100;
        spi_xfer(8'hE0, 3, 1'b0, mi);
        #20;
        chk("prerst_oe", 16'(miso_oe), 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("midrst_rx_data",  16'(rx_data),  16'h0000);
        chk("midrst_rx_valid", 16'(rx_valid), 16'h0000);
        chk("midrst_tx_ready", 16'(tx_ready), 16'h0000);
        chk("midrst_miso",     16'(miso),     16'h0000);
        chk("midrst_miso_oe",  16'(miso_oe),  16'h0000);
        #9;
        cs_n = 1'b1;
        #20;
        rst_n = 1'b1;
        #100;
        clear_counts();
        cs_n = 1'b0;
        #100;
        spi_xfer(8'h81, 8, 1'b0, mi);
        #100;
        cs_n = 1'b1;
        #200;
        chk("r81_rx_count", 16'(rx_cnt),  16'd1);
        chk("r81_rx_data",  16'(rx_data), 16'h0081);

        // No tx word available: 0x00 in, TX_IDLE out
        clear_counts();
        tx_valid = 1'b0;
        cs_n = 1'b0;
        #100;
        spi_xfer(8'h00, 8, 1'b1, mi);
        #200;
        chk("idle_miso",     16'(mi),      16'h00FF);
        chk("idle_rx_count", 16'(rx_cnt),  16'd1);
        chk("idle_rx_data",  16'(rx_data), 16'h0000);
`ifdef SPI_SLAVE_ERR_EN
        chk("idle_underrun", 16'(ur_cnt),  16'd1);
`endif

        // sclk activity while deselected is ignored
        clear_counts();
        cs_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mosi = i[0];
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
            #40;
        end
        #100;
        chk("desel_rx_count", 16'(rx_cnt),  16'd0);
        chk("desel_oe_count", 16'(oe_cnt),  16'd0);
        chk("desel_miso",     16'(miso),    16'h0000);
        chk("desel_rx_data",  16'(rx_data), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
